acc_tile_sched: RTL and testbench

//  Multi-tile sequencer for the conv accelerator. One ap_start processes num_tiles tiles.
//  Per tile, in order: AXI read-master fetch, one conv engine pass (op_start/end_conv),
//  AXI write-master store.

---
 rtl/acc_tile_sched.sv | 217 +++++++++++++++++++++
 tb/tb_acc_tile_sched.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_tile_sched.sv
// Multi-tile sequencer for the conv accelerator: for each tile it runs a read-master fetch,
// one conv engine pass and a write-master store, stepping src/dst addresses by TILE_BYTES.
module acc_tile_sched #(
  parameter int ADDR_W     = 64,
  parameter int TILE_W     = 16,
  parameter int TILE_BYTES = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ap_start,
  input  logic              ap_continue,
  output logic              ap_ready,
  output logic              ap_done,
  output logic              ap_idle,
  input  logic [TILE_W-1:0] num_tiles,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              rmst_start,
  output logic [ADDR_W-1:0] rmst_addr,
  input  logic              rmst_done,
  output logic              op_start,
  input  logic              end_conv,
  output logic              wmst_start,
  output logic [ADDR_W-1:0] wmst_addr,
  input  logic              wmst_done,
  output logic [TILE_W-1:0] tile_idx
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_OP_REQ  = 3'd3,
    S_CONV    = 3'd4,
    S_WR_REQ  = 3'd5,
    S_WR_WAIT = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(TILE_BYTES);
  localparam logic [TILE_W-1:0] TILE_ONE = {{(TILE_W-1){1'b0}}, 1'b1};

  // Address stepping wraps silently modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return a + STRIDE;
  endfunction

  state_t            state_q, state_d;
  logic [TILE_W-1:0] num_q, num_d;
  logic [TILE_W-1:0] tile_q, tile_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              rd_start_q, rd_start_d;
  logic              op_start_q, op_start_d;
  logic              wr_start_q, wr_start_d;
  logic              done_q, done_d;
  logic              idle_q, idle_d;
  logic              last_tile_s;

  assign last_tile_s = (tile_q == (num_q - TILE_ONE));

  // Next-state, tile bookkeeping and output decode; pulses follow the state being entered.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    tile_d  = tile_q;
    raddr_d = raddr_q;
    waddr_d = waddr_q;
    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          num_d   = num_tiles;
          tile_d  = {TILE_W{1'b0}};
          raddr_d = src_base;
          waddr_d = dst_base;
          if (num_tiles == {TILE_W{1'b0}}) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RD_REQ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_REQ: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (rmst_done) begin
          state_d = S_OP_REQ;
        end else begin
          state_d = S_RD_WAIT;
        end
      end
      S_OP_REQ: state_d = S_CONV;
      S_CONV: begin
        if (end_conv) begin
          state_d = S_WR_REQ;
        end else begin
          state_d = S_CONV;
        end
      end
      S_WR_REQ: state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (wmst_done) begin
          if (last_tile_s) begin
            state_d = S_DONE;
          end else begin
            tile_d  = tile_q + TILE_ONE;
            raddr_d = next_addr(raddr_q);
            waddr_d = next_addr(waddr_q);
            state_d = S_RD_REQ;
          end
        end else begin
          state_d = S_WR_WAIT;
        end
      end
      S_DONE: begin
        if (ap_continue) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rd_start_d = (state_d == S_RD_REQ);
    op_start_d = (state_d == S_OP_REQ);
    wr_start_d = (state_d == S_WR_REQ);
    done_d     = (state_d == S_DONE);
    idle_d     = (state_d == S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      num_q      <= {TILE_W{1'b0}};
      tile_q     <= {TILE_W{1'b0}};
      raddr_q    <= {ADDR_W{1'b0}};
      waddr_q    <= {ADDR_W{1'b0}};
      rd_start_q <= 1'b0;
      op_start_q <= 1'b0;
      wr_start_q <= 1'b0;
      done_q     <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      tile_q     <= tile_d;
      raddr_q    <= raddr_d;
      waddr_q    <= waddr_d;
      rd_start_q <= rd_start_d;
      op_start_q <= op_start_d;
      wr_start_q <= wr_start_d;
      done_q     <= done_d;
      idle_q     <= idle_d;
    end
  end

  assign ap_ready   = idle_q;
  assign ap_idle    = idle_q;
  assign ap_done    = done_q;
  assign rmst_start = rd_start_q;
  assign op_start   = op_start_q;
  assign wmst_start = wr_start_q;
  assign rmst_addr  = raddr_q;
  assign wmst_addr  = waddr_q;
  assign tile_idx   = tile_q;

  acc_tile_sched_chk u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .rmst_start (rd_start_q),
    .op_start   (op_start_q),
    .wmst_start (wr_start_q),
    .ap_done    (done_q),
    .ap_idle    (idle_q)
  );

endmodule

// Protocol checks: at most one of pulses/done/idle per cycle, and no back-to-back pulses.
module acc_tile_sched_chk (
  input logic clk,
  input logic rst_n,
  input logic rmst_start,
  input logic op_start,
  input logic wmst_start,
  input logic ap_done,
  input logic ap_idle
);

  logic pulse_prev_q;
  logic pulse_s;

  assign pulse_s = rmst_start | op_start | wmst_start;

  // Remember whether the previous cycle carried any start pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pulse_prev_q <= 1'b0;
    end else begin
      pulse_prev_q <= pulse_s;
    end
  end

  // Immediate checks evaluated once per cycle outside reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      a_exclusive: assert ($countones({rmst_start, op_start, wmst_start, ap_done, ap_idle}) <= 1);
      a_no_b2b:    assert (!(pulse_prev_q && pulse_s));
    end else begin
      a_rst_quiet: assert (!pulse_s || !pulse_prev_q);
    end
  end

endmodule

// File: tb/tb_acc_tile_sched.sv
// Self-checking bench for acc_tile_sched: vector table, hand-written corner sequences and
// randomized runs checked against a transaction-level tile/address model.
module tb_acc_tile_sched;

  localparam logic [63:0] STRIDE = 64'd4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ap_start = 1'b0;
  logic        ap_continue = 1'b0;
  logic        ap_ready, ap_done, ap_idle;
  logic [15:0] num_tiles = 16'd0;
  logic [63:0] src_base = 64'd0;
  logic [63:0] dst_base = 64'd0;
  logic        rmst_start, op_start, wmst_start;
  logic [63:0] rmst_addr, wmst_addr;
  logic        rmst_done = 1'b0;
  logic        end_conv = 1'b0;
  logic        wmst_done = 1'b0;
  logic [15:0] tile_idx;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  acc_tile_sched #(.ADDR_W(64), .TILE_W(16), .TILE_BYTES(4096)) dut (
    .clk(clk), .rst_n(rst_n), .ap_start(ap_start), .ap_continue(ap_continue),
    .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
    .num_tiles(num_tiles), .src_base(src_base), .dst_base(dst_base),
    .rmst_start(rmst_start), .rmst_addr(rmst_addr), .rmst_done(rmst_done),
    .op_start(op_start), .end_conv(end_conv),
    .wmst_start(wmst_start), .wmst_addr(wmst_addr), .wmst_done(wmst_done),
    .tile_idx(tile_idx)
  );

  typedef struct {
    int          n;
    logic [63:0] src;
    logic [63:0] dst;
    logic [63:0] frd;
    logic [63:0] lrd;
    logic [63:0] fwr;
    logic [63:0] lwr;
    int          lat;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input logic rd, input logic op, input logic wr,
                             input logic dn, input logic idl, input logic [15:0] t,
                             input logic [63:0] ra, input logic [63:0] wa);
    chk({tag, ".rmst_start"}, 64'(rmst_start), 64'(rd));
    chk({tag, ".op_start"},   64'(op_start),   64'(op));
    chk({tag, ".wmst_start"}, 64'(wmst_start), 64'(wr));
    chk({tag, ".ap_done"},    64'(ap_done),    64'(dn));
    chk({tag, ".ap_idle"},    64'(ap_idle),    64'(idl));
    chk({tag, ".ap_ready"},   64'(ap_ready),   64'(idl));
    chk({tag, ".tile_idx"},   64'(tile_idx),   64'(t));
    chk({tag, ".rmst_addr"},  rmst_addr,       ra);
    chk({tag, ".wmst_addr"},  wmst_addr,       wa);
  endtask

  // Non-awaited done inputs get random values; the awaited one (index k) stays low.
  task automatic drive_spur(input int k);
    logic [2:0] b;
    b = 3'($urandom);
    b[k] = 1'b0;
    rmst_done = b[0];
    end_conv  = b[1];
    wmst_done = b[2];
  endtask

  // One complete run with a responder answering every start pulse dly cycles later.
  task automatic run_fixed(input int n, input logic [63:0] s, input logic [63:0] d,
                           input int dly, input int cont_dly, input bit hold,
                           output int nrd, output int nop, output int nwr,
                           output logic [63:0] frd, output logic [63:0] lrd,
                           output logic [63:0] fwr, output logic [63:0] lwr, output int lat);
    int trd, top, twr, since_wr;
    bit seen;
    nrd = 0; nop = 0; nwr = 0; lat = -1;
    frd = 64'd0; lrd = 64'd0; fwr = 64'd0; lwr = 64'd0;
    trd = -1; top = -1; twr = -1; since_wr = 0; seen = 1'b0;
    num_tiles = 16'(n); src_base = s; dst_base = d; ap_start = 1'b1;
    step();
    ap_start = hold;
    num_tiles = 16'hFFFF; src_base = ~s; dst_base = ~d;
    for (int c = 0; c < 2000 && !seen; c++) begin
      since_wr++;
      if (rmst_start) begin
        if (nrd == 0) frd = rmst_addr;
        lrd = rmst_addr; nrd++; trd = dly;
      end
      if (op_start) begin
        nop++; top = dly;
      end
      if (wmst_start) begin
        if (nwr == 0) fwr = wmst_addr;
        lwr = wmst_addr; nwr++; twr = dly;
      end
      if (ap_done) begin
        seen = 1'b1;
        lat = since_wr;
      end else begin
        rmst_done = (trd == 0);
        end_conv  = (top == 0);
        wmst_done = (twr == 0);
        if (wmst_done) since_wr = 0;
        if (trd >= 0) trd--;
        if (top >= 0) top--;
        if (twr >= 0) twr--;
        step();
      end
    end
    rmst_done = 1'b0; end_conv = 1'b0; wmst_done = 1'b0;
    num_tiles = 16'(n); src_base = s; dst_base = d;
    chk("run.done_seen", 64'(seen), 64'd1);
    for (int c = 0; c < cont_dly; c++) begin
      step();
      chk("run.done_held", 64'(ap_done), 64'd1);
      chk("run.no_rd_in_done", 64'(rmst_start), 64'd0);
    end
    ap_continue = 1'b1;
    step();
    ap_continue = 1'b0;
    chk("run.idle_after_cont", 64'(ap_idle), 64'd1);
    chk("run.done_cleared", 64'(ap_done), 64'd0);
  endtask

  int          nrd, nop, nwr, lat;
  logic [63:0] frd, lrd, fwr, lwr;
  int          rn, lt;
  logic [63:0] rs, rd_b, ra, wa;

  initial begin
    vecs[0] = '{3, 64'h1000, 64'h8000, 64'h1000, 64'h3000, 64'h8000, 64'hA000, 1};
    vecs[1] = '{0, 64'h55, 64'h66, 64'h0, 64'h0, 64'h0, 64'h0, 1};
    vecs[2] = '{2, 64'hFFFF_FFFF_FFFF_F000, 64'h0, 64'hFFFF_FFFF_FFFF_F000, 64'h0,
                64'h0, 64'h1000, 1};
    vecs[3] = '{1, 64'h123, 64'hFFFF_FFFF_FFFF_FFFF, 64'h123, 64'h123,
                64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[4] = '{5, 64'h0, 64'h10_0000, 64'h0, 64'h4000, 64'h10_0000, 64'h10_4000, 1};

    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    expect_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 64'd0, 64'd0);

    // Vector table: fixed 5-cycle responder.
    for (int i = 0; i < 5; i++) begin
      run_fixed(vecs[i].n, vecs[i].src, vecs[i].dst, 5, 0, 1'b0,
                nrd, nop, nwr, frd, lrd, fwr, lwr, lat);
      chk("T.n_rmst", 64'(nrd), 64'(vecs[i].n));
      chk("T.n_op",   64'(nop), 64'(vecs[i].n));
      chk("T.n_wmst", 64'(nwr), 64'(vecs[i].n));
      chk("T.done_lat", 64'(lat), 64'(vecs[i].lat));
      if (vecs[i].n > 0) begin
        chk("T.first_rd", frd, vecs[i].frd);
        chk("T.last_rd",  lrd, vecs[i].lrd);
        chk("T.first_wr", fwr, vecs[i].fwr);
        chk("T.last_wr",  lwr, vecs[i].lwr);
      end
    end

    // Delayed ap_continue with ap_start held high throughout.
    run_fixed(1, 64'h4000, 64'h9000, 3, 20, 1'b1, nrd, nop, nwr, frd, lrd, fwr, lwr, lat);
    chk("A.n_rmst", 64'(nrd), 64'd1);
    step();
    expect_outs("A.restart", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 64'h4000, 64'h9000);
    ap_start = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    expect_outs("A.reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 64'd0, 64'd0);

    // Spurious done inputs, then reset while in CONV on tile 1.
    num_tiles = 16'd3; src_base = 64'h1000; dst_base = 64'h8000; ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    expect_outs("B.rd0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 64'h1000, 64'h8000);
    rmst_done = 1'b1; end_conv = 1'b1; wmst_done = 1'b1;
    step();
    rmst_done = 1'b0; end_conv = 1'b0; wmst_done = 1'b0;
    expect_outs("B.same_cycle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 64'h1000, 64'h8000);
    end_conv = 1'b1; wmst_done = 1'b1;
    step();
    end_conv = 1'b0; wmst_done = 1'b0;
    expect_outs("B.spur_rdwait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 64'h1000, 64'h8000);
    rmst_done = 1'b1;
    step();
    rmst_done = 1'b0;
    expect_outs("B.op0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 64'h1000, 64'h8000);
    step();
    wmst_done = 1'b1; rmst_done = 1'b1;
    step();
    wmst_done = 1'b0; rmst_done = 1'b0;
    expect_outs("B.spur_conv", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 64'h1000, 64'h8000);
    end_conv = 1'b1;
    step();
    end_conv = 1'b0;
    expect_outs("B.wr0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 64'h1000, 64'h8000);
    step();
    wmst_done = 1'b1;
    step();
    wmst_done = 1'b0;
    expect_outs("B.rd1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 64'h2000, 64'h9000);
    step();
    rmst_done = 1'b1;
    step();
    rmst_done = 1'b0;
    expect_outs("B.op1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 64'h2000, 64'h9000);
    step();
    rst_n = 1'b0; end_conv = 1'b1;
    step();
    rst_n = 1'b1; end_conv = 1'b0;
    expect_outs("B.reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 64'd0, 64'd0);
    step();
    expect_outs("B.post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 64'd0, 64'd0);
    num_tiles = 16'd1; src_base = 64'h7000; dst_base = 64'h3000; ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    expect_outs("B.fresh", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 64'h7000, 64'h3000);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    expect_outs("B.reset2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 64'd0, 64'd0);

    // Randomized runs against the tile/address model.
    for (int r = 0; r < 40; r++) begin
      rn = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 4));
      rs = {$urandom(), $urandom()};
      rd_b = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) rs = 64'hFFFF_FFFF_FFFF_F000 - 64'($urandom_range(0, 2)) * STRIDE;
      num_tiles = 16'(rn); src_base = rs; dst_base = rd_b; ap_start = 1'b1;
      step();
      ap_start = 1'($urandom_range(0, 1));
      num_tiles = 16'($urandom()); src_base = {$urandom(), $urandom()}; dst_base = {$urandom(), $urandom()};
      for (int t = 0; t < rn; t++) begin
        ra = rs + 64'(t) * STRIDE;
        wa = rd_b + 64'(t) * STRIDE;
        for (int k = 0; k < 3; k++) begin
          expect_outs("R.pulse", 1'(k == 0), 1'(k == 1), 1'(k == 2), 1'b0, 1'b0, 16'(t), ra, wa);
          {wmst_done, end_conv, rmst_done} = 3'($urandom());
          step();
          expect_outs("R.req", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'(t), ra, wa);
          repeat ($urandom_range(0, 3)) begin
            drive_spur(k);
            step();
            expect_outs("R.wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'(t), ra, wa);
          end
          drive_spur(k);
          case (k)
            0: rmst_done = 1'b1;
            1: end_conv = 1'b1;
            default: wmst_done = 1'b1;
          endcase
          step();
          rmst_done = 1'b0; end_conv = 1'b0; wmst_done = 1'b0;
        end
      end
      lt = (rn == 0) ? 0 : rn - 1;
      ra = rs + 64'(lt) * STRIDE;
      wa = rd_b + 64'(lt) * STRIDE;
      expect_outs("R.done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'(lt), ra, wa);
      repeat ($urandom_range(0, 4)) begin
        ap_start = 1'($urandom_range(0, 1));
        {wmst_done, end_conv, rmst_done} = 3'($urandom());
        step();
        expect_outs("R.hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'(lt), ra, wa);
      end
      ap_continue = 1'b1;
      ap_start = 1'($urandom_range(0, 1));
      step();
      ap_continue = 1'b0; ap_start = 1'b0;
      rmst_done = 1'b0; end_conv = 1'b0; wmst_done = 1'b0;
      expect_outs("R.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'(lt), ra, wa);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
